// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multicycle MIPS core with one shared instruction/data memory port
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   mem_req    : memory transfer request
//   mem_we     : 1 = write, 0 = read (meaningful only with mem_req)
//   mem_addr   : word-aligned byte address
//   mem_wdata  : store data
//   mem_rdata  : read data, valid with mem_ready
//   mem_ready  : transfer completes on an edge with mem_req & mem_ready
//   pc         : current program counter
//   halted     : core stopped on an illegal opcode or funct
//   retire     : one-cycle pulse on the last cycle of each instruction
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter bit          ZEXT_LOGICAL = 1'b1,
   parameter int          NUM_REGS     = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic        halted,
   output logic        retire
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_RTEXEC = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_IEXEC  = 4'd8;
   localparam logic [3:0] S_IWB    = 4'd9;
   localparam logic [3:0] S_BRANCH = 4'd10;
   localparam logic [3:0] S_JUMP   = 4'd11;
   localparam logic [3:0] S_HALT   = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   logic [3:0]  state;
   logic [31:0] ir;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_out;
   logic [31:0] mdr;
   logic [31:0] rf [0:31];

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm;
   logic [31:0] imm_sext;
   logic [31:0] imm_lext;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] diff;
   logic [31:0] r_result;
   logic        r_valid;
   logic [31:0] i_result;
   logic [3:0]  dispatch;
   logic        take_branch;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   assign opcode = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign imm    = ir[15:0];
   assign funct  = ir[5:0];

   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_lext = ZEXT_LOGICAL ? {16'h0000, imm} : imm_sext;

   // $0 and indices beyond the implemented file read as zero and ignore writes
   function automatic logic reg_ok(input logic [4:0] idx);
      return (idx != 5'd0) && (int'(idx) < NUM_REGS);
   endfunction

   assign rs_val = reg_ok(rs) ? rf[rs] : 32'h0;
   assign rt_val = reg_ok(rt) ? rf[rt] : 32'h0;

   // Shared subtractor: R-type sub and the branch comparison
   assign diff = a - b;

   always_comb begin
      r_result = 32'h0;
      r_valid  = 1'b1;
      case (funct)
         F_ADD:   r_result = a + b;
         F_SUB:   r_result = diff;
         F_AND:   r_result = a & b;
         F_OR:    r_result = a | b;
         F_SLT:   r_result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: r_valid  = 1'b0;
      endcase
   end

   always_comb begin
      i_result = 32'h0;
      case (opcode)
         OP_ADDI: i_result = a + imm_sext;
         OP_ANDI: i_result = a & imm_lext;
         OP_ORI:  i_result = a | imm_lext;
         OP_SLTI: i_result = ($signed(a) < $signed(imm_sext)) ? 32'd1 : 32'd0;
         default: i_result = 32'h0;
      endcase
   end

   always_comb begin
      dispatch = S_HALT;
      case (opcode)
         OP_LW, OP_SW:                     dispatch = S_MEMADR;
         OP_RTYPE:                         dispatch = S_RTEXEC;
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: dispatch = S_IEXEC;
         OP_BEQ, OP_BNE:                   dispatch = S_BRANCH;
         OP_J:                             dispatch = S_JUMP;
         default:                          dispatch = S_HALT;
      endcase
   end

   // BRANCH is only reachable for beq/bne, so anything not beq is bne
   assign take_branch = (opcode == OP_BEQ) ? (diff == 32'h0) : (diff != 32'h0);

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = rt;
      rf_wdata = alu_out;
      case (state)
         S_MEMWB: begin
            rf_we    = 1'b1;
            rf_wdata = mdr;
         end
         S_ALUWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
         end
         S_IWB:   rf_we = 1'b1;
         default: rf_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            rf[i] <= 32'h0;
         end
      end else if (rf_we && reg_ok(rf_waddr)) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   // Request fields come straight from state and registers that do not change
   // while the FSM waits, so they stay stable until the completing edge.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      mem_addr = {pc[31:2], 2'b00};
      case (state)
         S_FETCH: mem_req = 1'b1;
         S_MEMRD: begin
            mem_req  = 1'b1;
            mem_addr = {alu_out[31:2], 2'b00};
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            mem_addr = {alu_out[31:2], 2'b00};
         end
         default: mem_req = 1'b0;
      endcase
      if (reset) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
      end
   end

   assign mem_wdata = b;

   always_comb begin
      retire = 1'b0;
      case (state)
         S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEMWR: retire = mem_ready;
         default: retire = 1'b0;
      endcase
      if (reset) begin
         retire = 1'b0;
      end
   end

   assign halted = (state == S_HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_FETCH;
         pc      <= RESET_PC;
         ir      <= 32'h0;
         a       <= 32'h0;
         b       <= 32'h0;
         alu_out <= 32'h0;
         mdr     <= 32'h0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir    <= mem_rdata;
                  pc    <= pc + 32'd4;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               a       <= rs_val;
               b       <= rt_val;
               // Branch target computed speculatively from the incremented pc
               alu_out <= pc + {imm_sext[29:0], 2'b00};
               state   <= dispatch;
            end
            S_MEMADR: begin
               alu_out <= a + imm_sext;
               state   <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               if (mem_ready) begin
                  mdr   <= mem_rdata;
                  state <= S_MEMWB;
               end
            end
            S_MEMWB: state <= S_FETCH;
            S_MEMWR: begin
               if (mem_ready) begin
                  state <= S_FETCH;
               end
            end
            S_RTEXEC: begin
               if (r_valid) begin
                  alu_out <= r_result;
                  state   <= S_ALUWB;
               end else begin
                  state <= S_HALT;
               end
            end
            S_ALUWB: state <= S_FETCH;
            S_IEXEC: begin
               alu_out <= i_result;
               state   <= S_IWB;
            end
            S_IWB: state <= S_FETCH;
            S_BRANCH: begin
               if (take_branch) begin
                  pc <= alu_out;
               end
               state <= S_FETCH;
            end
            S_JUMP: begin
               pc    <= {pc[31:28], ir[25:0], 2'b00};
               state <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - scoreboard bench for mips_multicycle_core
module tb_mips_multicycle_core;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        reset2 = 1'b1;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic        mem_req2, mem_we2, retire2, halted2;
   logic        mem_ready2;
   logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          wait_cycles = 0;
   int          wcnt = 0;
   logic [31:0] mem [0:511];
   logic [31:0] exp_rd [$];
   logic [63:0] exp_wr [$];
   logic [63:0] exp_wr2 [$];
   int          exp_ret [$];
   logic        pend = 1'b0;
   logic        p_we;
   logic [31:0] p_addr, p_wdata;
   logic [63:0] w;

   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

   mips_multicycle_core #(.RESET_PC(32'h0), .ZEXT_LOGICAL(1'b1), .NUM_REGS(32)) dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
      .halted(halted), .retire(retire));

   mips_multicycle_core #(.RESET_PC(32'h0), .ZEXT_LOGICAL(1'b0), .NUM_REGS(8)) dut2 (
      .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
      .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .pc(pc2),
      .halted(halted2), .retire(retire2));

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] rom2(input logic [31:0] addr);
      case (addr)
         32'h00:  return itype(6'h0D, 5'd0, 5'd1, 16'h8001);
         32'h04:  return itype(6'h0C, 5'd1, 5'd2, 16'h8001);
         32'h08:  return itype(6'h2B, 5'd0, 5'd1, 16'h0080);
         32'h0C:  return itype(6'h2B, 5'd0, 5'd2, 16'h0084);
         32'h10:  return itype(6'h0D, 5'd0, 5'd9, 16'h0007);
         32'h14:  return itype(6'h2B, 5'd0, 5'd9, 16'h0088);
         default: return ILLEGAL;
      endcase
   endfunction

   assign mem_rdata  = mem[mem_addr[10:2]];
   assign mem_rdata2 = rom2(mem_addr2);
   assign mem_ready2 = 1'b1;

   always @(posedge clk) begin
      if (reset) cyc <= 1;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic flag(input string name, input logic [31:0] got);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %h expected none (cycle %0d)", name, got, cyc);
   endtask

   // Memory model and monitor: all sampling on the falling edge
   always @(negedge clk) begin
      if (pend && !reset) begin
         check("req_stable", {31'd0, mem_req}, 32'd1);
         check("we_stable", {31'd0, mem_we}, {31'd0, p_we});
         check("addr_stable", mem_addr, p_addr);
         check("wdata_stable", mem_wdata, p_wdata);
      end
      if (mem_req) begin
         mem_ready = (wcnt >= wait_cycles);
         wcnt = mem_ready ? 0 : wcnt + 1;
      end else begin
         mem_ready = 1'b0;
         wcnt = 0;
      end
      pend    = mem_req && !mem_ready;
      p_we    = mem_we;
      p_addr  = mem_addr;
      p_wdata = mem_wdata;
      if (mem_req && mem_ready) begin
         if (mem_we) begin
            mem[mem_addr[10:2]] = mem_wdata;
            if (exp_wr.size() == 0) flag("unexpected_write", mem_addr);
            else begin
               w = exp_wr.pop_front();
               check("write_addr", mem_addr, w[63:32]);
               check("write_data", mem_wdata, w[31:0]);
            end
         end else begin
            if (exp_rd.size() == 0) flag("unexpected_read", mem_addr);
            else check("read_addr", mem_addr, exp_rd.pop_front());
         end
      end
      if (retire) begin
         if (exp_ret.size() == 0) flag("unexpected_retire", cyc);
         else check("retire_cycle", cyc, exp_ret.pop_front());
      end
      if (mem_req2 && mem_we2 && !reset2) begin
         if (exp_wr2.size() == 0) flag("unexpected_write2", mem_addr2);
         else begin
            w = exp_wr2.pop_front();
            check("zext0_write_addr", mem_addr2, w[63:32]);
            check("zext0_write_data", mem_wdata2, w[31:0]);
         end
      end
   end

   task automatic start_reset();
      reset = 1'b1;
      #1;
      check("req_in_reset", {31'd0, mem_req}, 32'd0);
      @(posedge clk);
      for (int i = 0; i < 512; i++) mem[i] = ILLEGAL;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      check("pc_after_reset", pc, 32'h0);
      check("halted_after_reset", {31'd0, halted}, 32'd0);
      check("retire_after_reset", {31'd0, retire}, 32'd0);
   endtask

   task automatic wait_halt(input int exp_cyc, input logic [31:0] exp_pc);
      int t = 0;
      while (!halted && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!halted) flag("halt_timeout", pc);
      else begin
         check("halt_cycle", cyc, exp_cyc);
         check("halt_pc", pc, exp_pc);
      end
      repeat (3) begin
         @(negedge clk);
         #1;
         check("req_while_halted", {31'd0, mem_req}, 32'd0);
         check("pc_frozen", pc, exp_pc);
      end
      check("reads_left", exp_rd.size(), 32'd0);
      check("writes_left", exp_wr.size(), 32'd0);
      check("retires_left", exp_ret.size(), 32'd0);
   endtask

   initial begin
      int t;
      mem_ready = 1'b0;
      // ---- ALU, logical immediates, $0, zero-wait retire cadence
      wait_cycles = 0;
      start_reset();
      mem[0]  = itype(6'h08, 5'd0, 5'd1, 16'd5);
      mem[1]  = itype(6'h08, 5'd0, 5'd2, 16'hFFFD);
      mem[2]  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
      mem[3]  = rtype(5'd1, 5'd2, 5'd4, 6'h22);
      mem[4]  = rtype(5'd2, 5'd1, 5'd5, 6'h2A);
      mem[5]  = itype(6'h2B, 5'd0, 5'd3, 16'h0080);
      mem[6]  = itype(6'h2B, 5'd0, 5'd4, 16'h0084);
      mem[7]  = itype(6'h2B, 5'd0, 5'd5, 16'h0088);
      mem[8]  = itype(6'h0D, 5'd0, 5'd6, 16'h8001);
      mem[9]  = itype(6'h0C, 5'd2, 5'd7, 16'h8001);
      mem[10] = itype(6'h0A, 5'd2, 5'd8, 16'hFFFE);
      mem[11] = itype(6'h2B, 5'd0, 5'd6, 16'h008C);
      mem[12] = itype(6'h2B, 5'd0, 5'd7, 16'h0090);
      mem[13] = itype(6'h2B, 5'd0, 5'd8, 16'h0094);
      mem[14] = itype(6'h08, 5'd0, 5'd0, 16'd7);
      mem[15] = itype(6'h2B, 5'd0, 5'd0, 16'h0098);
      for (int i = 0; i <= 16; i++) exp_rd.push_back(32'(i * 4));
      for (int i = 1; i <= 16; i++) exp_ret.push_back(i * 4);
      exp_wr.push_back({32'h80, 32'd2});
      exp_wr.push_back({32'h84, 32'd8});
      exp_wr.push_back({32'h88, 32'd1});
      exp_wr.push_back({32'h8C, 32'h0000_8001});
      exp_wr.push_back({32'h90, 32'h0000_8001});
      exp_wr.push_back({32'h94, 32'd1});
      exp_wr.push_back({32'h98, 32'd0});
      exp_wr2.push_back({32'h80, 32'hFFFF_8001});
      exp_wr2.push_back({32'h84, 32'hFFFF_8001});
      exp_wr2.push_back({32'h88, 32'd0});
      reset2 = 1'b0;
      release_reset();
      wait_halt(67, 32'h44);
      check("zext0_writes_left", exp_wr2.size(), 32'd0);
      check("zext0_halted", {31'd0, halted2}, 32'd1);
      check("zext0_pc", pc2, 32'h1C);

      // ---- store/load with three wait cycles per transfer; illegal at 0x10
      start_reset();
      wait_cycles = 3;
      mem[0]    = itype(6'h08, 5'd0, 5'd1, 16'h1234);
      mem[1]    = itype(6'h2B, 5'd0, 5'd1, 16'h0040);
      mem[2]    = itype(6'h23, 5'd0, 5'd2, 16'h0040);
      mem[3]    = itype(6'h2B, 5'd0, 5'd2, 16'h0044);
      mem[16]   = 32'hDEAD_BEEF;
      exp_rd = '{32'h0, 32'h4, 32'h8, 32'h40, 32'hC, 32'h10};
      exp_ret = '{7, 17, 28, 38};
      exp_wr = '{{32'h40, 32'h1234}, {32'h44, 32'h1234}};
      release_reset();
      wait_halt(44, 32'h14);

      // ---- jump, bne not taken, beq taken backwards then not taken
      start_reset();
      wait_cycles = 0;
      mem[0]     = itype(6'h08, 5'd0, 5'd1, 16'd1);
      mem[1]     = {6'h02, 26'h100};
      mem[256]   = itype(6'h05, 5'd1, 5'd1, 16'd5);
      mem[257]   = itype(6'h08, 5'd2, 5'd2, 16'd1);
      mem[258]   = itype(6'h04, 5'd2, 5'd1, 16'hFFFE);
      mem[259]   = itype(6'h2B, 5'd0, 5'd2, 16'h0080);
      exp_rd = '{32'h0, 32'h4, 32'h400, 32'h404, 32'h408, 32'h404, 32'h408, 32'h40C, 32'h410};
      exp_ret = '{4, 7, 10, 14, 17, 21, 24, 28};
      exp_wr = '{{32'h80, 32'd2}};
      release_reset();
      wait_halt(31, 32'h414);

      // ---- reset clears the register file ($1=1, $2=2 before)
      start_reset();
      mem[0] = itype(6'h2B, 5'd0, 5'd1, 16'h0080);
      mem[1] = itype(6'h2B, 5'd0, 5'd2, 16'h0084);
      exp_rd = '{32'h0, 32'h4, 32'h8};
      exp_ret = '{4, 8};
      exp_wr = '{{32'h80, 32'd0}, {32'h84, 32'd0}};
      release_reset();
      wait_halt(11, 32'hC);

      // ---- reset in the middle of a lw data wait
      start_reset();
      wait_cycles = 3;
      mem[0]  = itype(6'h23, 5'd0, 5'd3, 16'h0040);
      mem[16] = 32'h0000_0055;
      exp_rd = '{32'h0};
      release_reset();
      t = 0;
      while (cyc != 8 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("midwait_req", {31'd0, mem_req}, 32'd1);
      check("midwait_we", {31'd0, mem_we}, 32'd0);
      check("midwait_addr", mem_addr, 32'h40);
      reset = 1'b1;
      #1;
      check("req_dropped_in_reset", {31'd0, mem_req}, 32'd0);
      check("reads_before_abort", exp_rd.size(), 32'd0);
      @(posedge clk);
      wait_cycles = 0;
      for (int i = 0; i < 512; i++) mem[i] = ILLEGAL;
      mem[0] = itype(6'h2B, 5'd0, 5'd3, 16'h0084);
      exp_rd = '{32'h0, 32'h4};
      exp_ret = '{4};
      exp_wr = '{{32'h84, 32'd0}};
      release_reset();
      wait_halt(7, 32'h8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Parametrised multicycle MIPS core: datapath plus internal control FSM sharing one unified memory port with a ready/request handshake. Each instruction runs over several cycles with one ALU and one memory port. Successor to the single-cycle datapath: it adds variable-latency memory, bne, a selectable immediate-extension mode, a halt on illegal opcodes, and a retire strobe. It sits between the testbench/top level and a single instruction+data memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
ZEXT_LOGICAL, 1, 1: andi/ori zero-extend imm16; 0: sign-extend imm16.
NUM_REGS, 32, register file entries; 2..32; indices ≥ NUM_REGS read 0 and writes are dropped.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high.
mem_req  out  1  memory transfer request.
mem_we  out  1  1 = write, 0 = read; valid only with mem_req.
mem_addr  out  32  byte address, word aligned.
mem_wdata  out  32  store data.
mem_rdata  in  32  read data; valid when mem_ready=1.
mem_ready  in  1  transfer completes on an edge where mem_req & mem_ready.
pc  out  32  current PC.
halted  out  1  core is stopped on an illegal opcode.
retire  out  1  one-cycle pulse on the final cycle of each instruction.

Behaviour:
- Reset: sampled on rising clk only. Loads pc=RESET_PC, state=FETCH, clears all registers, halted=0, retire=0. mem_req is forced 0 while reset=1.
- Reset during an open memory transfer abandons it. The memory must tolerate a dropped request.
- Handshake: mem_req, mem_we, mem_addr and mem_wdata stay stable from request assertion until the completing edge. Zero-wait memory (mem_ready high in the same cycle) is legal. mem_ready is ignored when mem_req=0. A state that waits on memory holds until completion.
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP, HALT.
  - FETCH: read at pc. On completion, IR←mem_rdata and pc←pc+4. Go to DECODE.
  - DECODE: A←rf[rs], B←rf[rt], ALUOut←pc+(sext(imm16)<<2). Dispatch by opcode:
    - lw/sw→MEMADR
    - R-type→RTEXEC
    - addi/andi/ori/slti→IEXEC
    - beq/bne→BRANCH
    - j→JUMP
    - anything else→HALT
  - MEMADR: ALUOut←A+sext(imm16). lw→MEMRD, sw→MEMWR.
  - MEMRD: read at ALUOut. On completion, MDR←rdata, go to MEMWB.
  - MEMWB: rt←MDR; retire; go to FETCH.
  - MEMWR: write B to ALUOut. On completion, retire; go to FETCH.
  - RTEXEC: funct add(20)/sub(22)/and(24)/or(25)/slt(2A). Unknown funct→HALT. Then go to ALUWB.
  - ALUWB: rd←ALUOut; retire; go to FETCH.
  - IEXEC: computes A op ext(imm16). slti is signed and sign-extended. Then IWB: rt←ALUOut; retire; go to FETCH.
  - BRANCH: compute A−B. Take the branch if beq&zero or bne&!zero: pc←ALUOut (target from DECODE). Retire; go to FETCH.
  - JUMP: pc←{pc[31:28], IR[25:0], 2'b00}, using pc already incremented. Retire; go to FETCH.
  - HALT: absorbing until reset. halted=1, mem_req=0, retire=0, pc frozen at the address after the illegal instruction.
- Arithmetic: 32-bit wraparound, no overflow traps. slt is signed. Writes to $0 are dropped; $0 always reads 0.
- Latency (zero-wait memory, cycles from FETCH entry to retire inclusive):
  - beq/bne/j: 3
  - R-type, I-ALU, sw: 4
  - lw: 5
  - Each extra wait cycle on any transfer adds 1.
- The register file reads A/B in DECODE, so a write in the writeback state is visible to the next instruction's DECODE. There are no hazards.

Test Plan:
- Zero-wait program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$1,$2; slt $5,$2,$1` → $3=2, $4=8, $5=1. Retire pulses at cycles 4,8,12,16,20 after reset release.
- ori/andi with imm 0x8001, both ZEXT_LOGICAL settings: ZEXT_LOGICAL=1 → `ori $1,$0,0x8001` gives 0x0000_8001. ZEXT_LOGICAL=0 → 0xFFFF_8001.
- `sw $1,0x40($0)` then `lw $2,0x40($0)` with mem_ready delayed 3 cycles on every transfer → request fields stable throughout each wait. $2 equals $1. lw retires 5+6=11 cycles after its FETCH begins.
- `beq` taken with offset −2 and `bne` not taken; `j 0x100` → next fetch addresses are PC+4−8, PC+4, and 0x400 respectively.
- Illegal opcode 0x3F at address 0x10 → halted=1 next cycle, mem_req stays 0, pc=0x14. Reset pulse → pc=RESET_PC, halted=0, registers cleared.
- Reset asserted mid-wait in MEMRD → mem_req=0 during reset, FETCH at RESET_PC after release, and the destination register is not written.
